// File: rtl/interrupt_request_unit_pkg.sv
// Shared constants for the interrupt request unit: register addresses,
// source bit indices and the fill value for IF's unimplemented upper bits.
package interrupt_request_unit_pkg;

  localparam int          NUM_INT_SOURCES = 5;
  localparam logic [15:0] IF_REG_ADDR     = 16'hFF0F;
  localparam logic [15:0] IE_REG_ADDR     = 16'hFFFF;
  localparam logic [2:0]  IF_UNUSED_FILL  = 3'b111;

  typedef enum int {
    INT_VBLANK = 0,
    INT_STAT   = 1,
    INT_TIMER  = 2,
    INT_SERIAL = 3,
    INT_JOYPAD = 4
  } int_source_e;

endpackage

// File: rtl/interrupt_request_unit_edge_detect.sv
// Rising-edge detector: flags bits that are high now but were low on the
// previous enabled clock.
module interrupt_request_unit_edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             i_Clk,
  input  logic             i_nRst,
  input  logic             i_Enable,
  input  logic [WIDTH-1:0] i_Level,
  output logic [WIDTH-1:0] o_Rise
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      prev_q <= '0;
    end else if (i_Enable) begin
      prev_q <= i_Level;
    end
  end

  assign o_Rise = i_Level & ~prev_q;

endmodule

// File: rtl/interrupt_request_unit.sv
// Interrupt flag/enable registers with source edge capture and dispatch
// acknowledge; presents pending & enabled requests to the control unit.
module interrupt_request_unit
  import interrupt_request_unit_pkg::*;
#(
  parameter int          NUM_SOURCES = NUM_INT_SOURCES,
  parameter logic [15:0] IF_ADDR     = IF_REG_ADDR,
  parameter logic [15:0] IE_ADDR     = IE_REG_ADDR
) (
  input  logic                   i_Clk,
  input  logic                   i_nRst,
  input  logic                   i_Enable,
  input  logic [NUM_SOURCES-1:0] i_Sources,
  input  logic [15:0]            i_Address,
  input  logic [7:0]             i_Data,
  input  logic                   i_Write,
  input  logic                   i_Read,
  output logic [7:0]             o_Data,
  output logic                   o_Selected,
  output logic [NUM_SOURCES-1:0] o_Interrupts,
  input  logic                   i_Handle_Interrupt
);

  // Bit 0 wins, matching the control unit's vector encoding of o_Interrupts.
  function automatic logic [NUM_SOURCES-1:0] lowest_set(input logic [NUM_SOURCES-1:0] v);
    lowest_set = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (v[i] && (lowest_set == '0)) lowest_set[i] = 1'b1;
    end
  endfunction

  logic [NUM_SOURCES-1:0] if_q;
  logic [7:0]             ie_q;
  logic [NUM_SOURCES-1:0] src_rise;
  logic [0:0]             ack_rise;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] ack_mask;
  logic [NUM_SOURCES-1:0] if_base;
  logic [NUM_SOURCES-1:0] if_next;
  logic [7:0]             if_rd;
  logic                   if_hit;
  logic                   ie_hit;

  interrupt_request_unit_edge_detect #(.WIDTH(NUM_SOURCES)) u_src_edge (
    .i_Clk    (i_Clk),
    .i_nRst   (i_nRst),
    .i_Enable (i_Enable),
    .i_Level  (i_Sources),
    .o_Rise   (src_rise)
  );

  interrupt_request_unit_edge_detect #(.WIDTH(1)) u_ack_edge (
    .i_Clk    (i_Clk),
    .i_nRst   (i_nRst),
    .i_Enable (i_Enable),
    .i_Level  (i_Handle_Interrupt),
    .o_Rise   (ack_rise)
  );

  assign if_hit   = (i_Address == IF_ADDR);
  assign ie_hit   = (i_Address == IE_ADDR);
  assign pending  = if_q & ie_q[NUM_SOURCES-1:0];
  assign ack_mask = ack_rise[0] ? lowest_set(pending) : '0;

  // A fresh source edge beats an ack clear, which beats a bus write.
  assign if_base = (i_Write && if_hit) ? i_Data[NUM_SOURCES-1:0] : if_q;
  assign if_next = (if_base & ~ack_mask) | src_rise;

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      if_q <= '0;
      ie_q <= '0;
    end else if (i_Enable) begin
      if_q <= if_next;
      if (i_Write && ie_hit) ie_q <= i_Data;
    end
  end

  assign if_rd = {{(8-NUM_SOURCES){IF_UNUSED_FILL[0]}}, if_q};

  always_comb begin
    o_Data = 8'h00;
    if (i_Read) begin
      if (if_hit)      o_Data = if_rd;
      else if (ie_hit) o_Data = ie_q;
    end
  end

  assign o_Selected   = if_hit || ie_hit;
  assign o_Interrupts = pending;

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Directed bench for interrupt_request_unit: edge capture, ack priority,
// bus access, enable gating and asynchronous reset.
module tb_interrupt_request_unit;

  logic        i_Clk;
  logic        i_nRst;
  logic        i_Enable;
  logic [4:0]  i_Sources;
  logic [15:0] i_Address;
  logic [7:0]  i_Data;
  logic        i_Write;
  logic        i_Read;
  logic [7:0]  o_Data;
  logic        o_Selected;
  logic [4:0]  o_Interrupts;
  logic        i_Handle_Interrupt;

  int checks = 0;
  int errors = 0;

  interrupt_request_unit dut (
    .i_Clk              (i_Clk),
    .i_nRst             (i_nRst),
    .i_Enable           (i_Enable),
    .i_Sources          (i_Sources),
    .i_Address          (i_Address),
    .i_Data             (i_Data),
    .i_Write            (i_Write),
    .i_Read             (i_Read),
    .o_Data             (o_Data),
    .o_Selected         (o_Selected),
    .o_Interrupts       (o_Interrupts),
    .i_Handle_Interrupt (i_Handle_Interrupt)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [7:0] expected);
    i_Address = addr;
    i_Read    = 1'b1;
    #1;
    chk(tag, o_Data, expected);
    i_Read    = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    i_Address = addr;
    i_Data    = data;
    i_Write   = 1'b1;
    step();
    i_Write   = 1'b0;
  endtask

  initial begin
    i_nRst = 1'b0; i_Enable = 1'b1; i_Sources = '0; i_Address = '0;
    i_Data = '0; i_Write = 1'b0; i_Read = 1'b0; i_Handle_Interrupt = 1'b0;
    #2;
    chk("rst_irq", {3'b0, o_Interrupts}, 8'h00);
    chk("rst_data_noread", o_Data, 8'h00);
    i_Address = 16'hFF0F; #1;
    chk("sel_if", {7'b0, o_Selected}, 8'h01);
    i_Address = 16'h1234; #1;
    chk("sel_none", {7'b0, o_Selected}, 8'h00);
    rd_chk("rd_unselected", 16'h1234, 8'h00);
    #6 i_nRst = 1'b1;
    step();

    // 1: single source edge, one-cycle latency
    wr(16'hFFFF, 8'h1F);
    rd_chk("t1_ie", 16'hFFFF, 8'h1F);
    i_Sources = 5'b00100; #1;
    chk("t1_latency", {3'b0, o_Interrupts}, 8'h00);
    step();
    chk("t1_irq", {3'b0, o_Interrupts}, 8'h04);
    rd_chk("t1_if", 16'hFF0F, 8'hE4);
    wr(16'hFF0F, 8'h00);
    i_Sources = '0;
    step();
    chk("t1_cleared", {3'b0, o_Interrupts}, 8'h00);

    // 2: two sources, acks clear lowest first; a held ack clears only one bit
    i_Sources = 5'b01001; step();
    chk("t2_irq", {3'b0, o_Interrupts}, 8'h09);
    i_Sources = '0;
    i_Handle_Interrupt = 1'b1; step();
    rd_chk("t2_ack1", 16'hFF0F, 8'hE8);
    step();
    rd_chk("t2_held", 16'hFF0F, 8'hE8);
    i_Handle_Interrupt = 1'b0; step();
    i_Handle_Interrupt = 1'b1; step();
    rd_chk("t2_ack2", 16'hFF0F, 8'hE0);
    i_Handle_Interrupt = 1'b0; step();

    // 3: ack only clears an enabled bit
    wr(16'hFFFF, 8'h04);
    wr(16'hFF0F, 8'h05);
    chk("t3_irq", {3'b0, o_Interrupts}, 8'h04);
    i_Handle_Interrupt = 1'b1; step();
    rd_chk("t3_if", 16'hFF0F, 8'hE1);
    i_Handle_Interrupt = 1'b0; step();
    chk("t3_irq_after", {3'b0, o_Interrupts}, 8'h00);

    // 4: write, ack and new edge on the same bit in one cycle
    wr(16'hFFFF, 8'h1F);
    wr(16'hFF0F, 8'h02);
    i_Address = 16'hFF0F; i_Data = 8'h00; i_Write = 1'b1;
    i_Handle_Interrupt = 1'b1; i_Sources = 5'b00010;
    step();
    i_Write = 1'b0; i_Handle_Interrupt = 1'b0;
    rd_chk("t4_if", 16'hFF0F, 8'hE2);
    i_Sources = '0; step();

    // read during write returns the pre-write value
    i_Address = 16'hFF0F; i_Data = 8'h1F; i_Write = 1'b1; i_Read = 1'b1; #1;
    chk("rdwr_pre", o_Data, 8'hE2);
    step();
    i_Write = 1'b0;
    chk("rdwr_post", o_Data, 8'hFF);
    i_Read = 1'b0;
    wr(16'hFF0F, 8'h00);

    // 5: held level sets once
    i_Sources = 5'b10000; step();
    rd_chk("t5_set", 16'hFF0F, 8'hF0);
    repeat (9) step();
    wr(16'hFF0F, 8'h00);
    repeat (3) step();
    rd_chk("t5_stays_clear", 16'hFF0F, 8'hE0);
    i_Sources = '0; step();
    i_Sources = 5'b10000; step();
    rd_chk("t5_reraise", 16'hFF0F, 8'hF0);

    // 6: enable low freezes state; the pending edge lands once re-enabled
    i_Enable = 1'b0; i_Sources = 5'b00001;
    wr(16'hFFFF, 8'h00);
    rd_chk("t6_ie_frozen", 16'hFFFF, 8'h1F);
    rd_chk("t6_if_frozen", 16'hFF0F, 8'hF0);
    i_Enable = 1'b1; step();
    rd_chk("t6_if_resume", 16'hFF0F, 8'hF1);
    chk("t6_irq", {3'b0, o_Interrupts}, 8'h11);

    // reset mid-dispatch
    i_Handle_Interrupt = 1'b1;
    i_nRst = 1'b0; #1;
    chk("rst_mid_irq", {3'b0, o_Interrupts}, 8'h00);
    rd_chk("rst_mid_ie", 16'hFFFF, 8'h00);
    i_Handle_Interrupt = 1'b0; i_Sources = '0;
    step();
    i_nRst = 1'b1; step();
    rd_chk("rst_mid_if", 16'hFF0F, 8'hE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
